// File: rtl/interval_timer_if.sv
// Signals between the interval timer, its controller and the time-parameter block.
interface interval_timer_if;
  logic       start;         // one-cycle request from the controller
  logic [1:0] interval_req;  // requested interval code
  logic [1:0] interval;      // registered select to the parameter block
  logic [3:0] value;         // registered duration from the parameter block
  logic       busy;
  logic [3:0] remaining;
  logic       expired;
  logic       tick;

  // Environment side: controller plus parameter block.
  modport master (
    output start, interval_req, value,
    input  interval, busy, remaining, expired, tick
  );

  // Timer side.
  modport slave (
    input  start, interval_req, value,
    output interval, busy, remaining, expired, tick
  );
endinterface

// File: rtl/interval_timer.sv
// Interval timer: selects a duration code, fetches its length in seconds from the
// parameter block, counts it down using a built-in prescaler and pulses expired.
module interval_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,  // clk cycles per 1 s tick, >= 2
  parameter int unsigned PW       = 27            // prescaler width, 2^PW >= TICK_DIV
) (
  input logic             clk,
  input logic             reset_n,
  interval_timer_if.slave tmr_if
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StCount, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      interval_q, interval_d;
  logic [3:0]      remaining_q, remaining_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            wrap;

  assign wrap = (presc_q == PW'(TICK_DIV - 1));

  // Next-state logic; a start in any state aborts and restarts from FETCH.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    if (tmr_if.start) begin
      interval_d  = tmr_if.interval_req;
      state_d     = StFetch;
      presc_d     = '0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        // Parameter block registers value for the new select during this cycle.
        StFetch: state_d = StWait;
        StWait: begin
          remaining_d = tmr_if.value;
          presc_d     = '0;
          state_d     = (tmr_if.value == 4'd0) ? StDone : StCount;
        end
        StCount: begin
          if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (remaining_q <= 4'd1) begin
              remaining_d = '0;
              state_d     = StDone;
            end else begin
              remaining_d = remaining_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      interval_q  <= 2'b00;
      remaining_q <= 4'd0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
    end
  end

  // Moore outputs.
  always_comb begin
    tmr_if.interval  = interval_q;
    tmr_if.remaining = remaining_q;
    tmr_if.tick      = tick_q;
    tmr_if.busy      = (state_q == StFetch) || (state_q == StWait) || (state_q == StCount);
    tmr_if.expired   = (state_q == StDone);
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_DIV=4 and a registered parameter-block model.
module tb_interval_timer;

  localparam int unsigned TickDiv = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  interval_timer_if tmr_if ();

  interval_timer #(.TICK_DIV(TickDiv), .PW(3)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .tmr_if (tmr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parameter block: durations per code, registered one clk after the select.
  logic [3:0] lut [4];
  initial begin
    lut[0] = 4'd6;
    lut[1] = 4'd3;
    lut[2] = 4'd2;
    lut[3] = 4'd0;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmr_if.value <= 4'd0;
    else          tmr_if.value <= lut[tmr_if.interval];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge is edge N.
  task automatic start_req(input logic [1:0] req);
    tmr_if.start        = 1'b1;
    tmr_if.interval_req = req;
    @(posedge clk);
    #1;
    tmr_if.start = 1'b0;
  endtask

  // Checks outputs after edges N..N+kmax against the latency model; ends at a negedge.
  task automatic track(input string name, input int req, input int v, input int kmax);
    int end_k;
    int exp_rem, exp_tick, exp_exp, exp_busy;
    end_k = 2 + int'(TickDiv) * v;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      exp_rem  = (k >= 2 && k < end_k) ? v - (k - 2) / int'(TickDiv) : 0;
      exp_tick = (k > 2 && (k - 2) % int'(TickDiv) == 0 && (k - 2) / int'(TickDiv) <= v) ? 1 : 0;
      exp_exp  = (k == end_k) ? 1 : 0;
      exp_busy = (k < end_k) ? 1 : 0;
      check($sformatf("%s k=%0d interval", name, k), 32'(tmr_if.interval), 32'(req));
      check($sformatf("%s k=%0d remaining", name, k), 32'(tmr_if.remaining), 32'(exp_rem));
      check($sformatf("%s k=%0d tick", name, k), 32'(tmr_if.tick), 32'(exp_tick));
      check($sformatf("%s k=%0d expired", name, k), 32'(tmr_if.expired), 32'(exp_exp));
      check($sformatf("%s k=%0d busy", name, k), 32'(tmr_if.busy), 32'(exp_busy));
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    int n_exp, n_tick, n_busy, n_rem, n_int;
    n_exp = 0; n_tick = 0; n_busy = 0; n_rem = 0; n_int = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tmr_if.expired)           n_exp++;
      if (tmr_if.tick)              n_tick++;
      if (tmr_if.busy)              n_busy++;
      if (tmr_if.remaining != 4'd0) n_rem++;
      if (tmr_if.interval != 2'b00) n_int++;
    end
    check({name, " expired cycles"}, 32'(n_exp), 32'd0);
    check({name, " tick cycles"}, 32'(n_tick), 32'd0);
    check({name, " busy cycles"}, 32'(n_busy), 32'd0);
    check({name, " nonzero remaining"}, 32'(n_rem), 32'd0);
    check({name, " nonzero interval"}, 32'(n_int), 32'd0);
  endtask

  initial begin
    tmr_if.start        = 1'b0;
    tmr_if.interval_req = 2'b00;
    reset_n             = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    idle_check("reset idle", 20);

    // Yellow, 2 s.
    start_req(2'b10);
    track("yellow", 2, 2, 13);

    // Base, 6 s.
    start_req(2'b00);
    track("base", 0, 6, 29);

    // Code 11 returning 0: no countdown.
    start_req(2'b11);
    track("zero", 3, 0, 5);

    // Extension aborted at remaining=2 by a yellow request.
    start_req(2'b01);
    track("abort first", 1, 3, 6);
    start_req(2'b10);
    track("abort second", 2, 2, 13);

    // Asynchronous reset mid-count at remaining=4.
    start_req(2'b00);
    track("pre-reset", 0, 6, 10);
    reset_n = 1'b0;
    #1;
    check("async reset interval", 32'(tmr_if.interval), 32'd0);
    check("async reset remaining", 32'(tmr_if.remaining), 32'd0);
    check("async reset busy", 32'(tmr_if.busy), 32'd0);
    check("async reset expired", 32'(tmr_if.expired), 32'd0);
    check("async reset tick", 32'(tmr_if.tick), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("post-reset idle", 10);

    // Normal operation after reset.
    start_req(2'b10);
    track("after reset", 2, 2, 13);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
